// File: rtl/alu_result_bcd_pkg.sv
// Shared definitions for the ALU result to BCD conversion stage:
// FSM state encodings, default widths and the BCD digit width.
package alu_result_bcd_pkg;

  // Default ALU result width and number of BCD digits produced.
  localparam int DATA_W_DEF = 8;
  localparam int NDIG_DEF   = 3;

  // Width of one BCD digit.
  localparam int DIG_W      = 4;

  // Converter FSM encodings; 2'b11 is unused and recovers to idle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage : alu_result_bcd_pkg

// File: rtl/alu_result_bcd_add3.sv
// Single-digit double-dabble correction: a digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3
  import alu_result_bcd_pkg::*;
(
  input  logic [DIG_W-1:0] d_i,
  output logic [DIG_W-1:0] d_o
);

  // Pure combinational correction, no state.
  always_comb begin
    d_o = d_i;
    if (d_i >= DIG_W'(5)) begin
      d_o = d_i + DIG_W'(3);
    end
  end

endmodule : bcd_add3

// File: rtl/alu_result_bcd.sv
// ALU result to BCD converter. Accepts one DATA_W-bit result with its
// overflow flag, runs a DATA_W-cycle shift-add-3 conversion and holds the
// NDIG BCD digits until the consumer takes them.
// Optional feature: define SIGNED_DISPLAY_EN to treat in_data as two's
// complement, converting its magnitude and reporting the sign on sign_out.
// NDIG must be large enough that 10**NDIG > 2**DATA_W - 1.
module alu_result_bcd
  import alu_result_bcd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NDIG   = NDIG_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  on,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIG_W*NDIG-1:0] bcd,
  output logic                  ovf_out,
  output logic                  sign_out,
  output logic [1:0]            state
);

  localparam int BCD_W  = DIG_W * NDIG;
  localparam int WORK_W = BCD_W + DATA_W;
  localparam int CNT_W  = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_e              state_q;
  logic [WORK_W-1:0]   work_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BCD_W-1:0]    bcd_q;
  logic                ovf_q;
  logic                ovf_pend_q;
  logic                out_valid_q;

  logic [DATA_W-1:0]   mag_d;
  logic [WORK_W-1:0]   work_adj;
  logic [WORK_W-1:0]   work_d;
  logic                accept;

  assign in_ready = (state_q == S_IDLE) && on;
  assign accept   = in_valid && in_ready;

`ifdef SIGNED_DISPLAY_EN
  logic sign_q;
  logic sign_pend_q;
  logic sign_d;

  // Two's complement magnitude; the most negative value maps to 2**(DATA_W-1).
  always_comb begin
    sign_d = in_data[DATA_W-1];
    mag_d  = in_data;
    if (sign_d) begin
      mag_d = ~in_data + DATA_W'(1);
    end
  end

  // Sign is captured with the operand and published together with the digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q      <= 1'b0;
      sign_pend_q <= 1'b0;
    end else begin
      if (accept) begin
        sign_pend_q <= sign_d;
      end
      if ((state_q == S_SHIFT) && (cnt_q == CNT_LAST)) begin
        sign_q <= sign_pend_q;
      end
    end
  end

  assign sign_out = sign_q;
`else
  assign mag_d    = in_data;
  assign sign_out = 1'b0;
`endif

  // The binary bits below the BCD field pass through untouched.
  assign work_adj[DATA_W-1:0] = work_q[DATA_W-1:0];

  // One correction unit per BCD digit of the work register.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .d_i (work_q  [DATA_W + gi*DIG_W +: DIG_W]),
        .d_o (work_adj[DATA_W + gi*DIG_W +: DIG_W])
      );
    end
  endgenerate

  // Correct then shift; the bit shifted out of the top digit is always zero.
  assign work_d = work_adj << 1;

  // Converter FSM with registered digit, flag and valid outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      ovf_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            work_q     <= {{BCD_W{1'b0}}, mag_d};
            cnt_q      <= '0;
            ovf_pend_q <= in_ovf;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_q       <= '0;
            bcd_q       <= work_d[WORK_W-1 -: BCD_W];
            ovf_q       <= ovf_pend_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign ovf_out   = ovf_q;
  assign state     = state_q;

endmodule : alu_result_bcd

// File: tb/tb_alu_result_bcd.sv
// Self-checking bench for alu_result_bcd. Expected digits come from plain
// decimal arithmetic on the operand; honours SIGNED_DISPLAY_EN if defined.
module tb_alu_result_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        on;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd;
  logic        ovf_out;
  logic        sign_out;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_result_bcd dut (
    .clk       (clk),
    .rst       (rst),
    .on        (on),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ovf    (in_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .ovf_out   (ovf_out),
    .sign_out  (sign_out),
    .state     (state)
  );

  // Reference: decimal digits of the displayed magnitude.
  function automatic logic [11:0] model_bcd(input logic [7:0] d);
    int m;
`ifdef SIGNED_DISPLAY_EN
    m = d[7] ? (256 - int'(d)) : int'(d);
`else
    m = int'(d);
`endif
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic model_sign(input logic [7:0] d);
`ifdef SIGNED_DISPLAY_EN
    return d[7];
`else
    return 1'b0 & d[7];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand, then count edges until out_valid (bounded).
  task automatic do_convert(input logic [7:0] d, input logic ovf, input bit drop_on,
                            output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_ovf   = ovf;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_ovf   = $urandom;
    if (drop_on) on = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    on = 1'b1;
    $display("[TB] conv data=%02h ovf=%0b lat=%0d bcd=%03h ovf_out=%0b sign=%0b",
             d, ovf, lat, bcd, ovf_out, sign_out);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; on = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_ovf = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if ({state, out_valid, bcd, ovf_out, sign_out, in_ready} !== {2'b00, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset: state=%b ov=%b bcd=%h ovf=%b sign=%b rdy=%b", state, out_valid, bcd, ovf_out, sign_out, in_ready);
    end
    $display("[TB] reset state=%b bcd=%03h", state, bcd);
  endtask

  task automatic test_directed();
    logic [7:0] vec_d [4] = '{8'hFF, 8'h00, 8'h2A, 8'h80};
    logic       vec_o [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_convert(vec_d[i], vec_o[i], 1'b0, lat);
      tests++;
      if (lat !== 8) begin
        fails++;
        $display("FAIL dir_latency data=%02h: got %0d want 8", vec_d[i], lat);
      end
      tests++;
      if ({bcd, ovf_out, sign_out} !== {model_bcd(vec_d[i]), vec_o[i], model_sign(vec_d[i])}) begin
        fails++;
        $display("FAIL dir_result data=%02h: got bcd=%h ovf=%b sign=%b want bcd=%h ovf=%b sign=%b",
                 vec_d[i], bcd, ovf_out, sign_out, model_bcd(vec_d[i]), vec_o[i], model_sign(vec_d[i]));
      end
      consume();
      tests++;
      if ({state, out_valid, bcd} !== {2'b00, 1'b0, model_bcd(vec_d[i])}) begin
        fails++;
        $display("FAIL dir_release data=%02h: state=%b ov=%b bcd=%h", vec_d[i], state, out_valid, bcd);
      end
    end
  endtask

  task automatic test_signed_cases();
    logic [7:0] d;
    int lat;
    d = 8'hF6;
    do_convert(d, 1'b0, 1'b0, lat);
    tests++;
`ifdef SIGNED_DISPLAY_EN
    if ({bcd, sign_out} !== {12'h010, 1'b1}) begin
`else
    if ({bcd, sign_out} !== {12'h246, 1'b0}) begin
`endif
      fails++;
      $display("FAIL signed_f6: got bcd=%h sign=%b", bcd, sign_out);
    end
    consume();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       o;
    bit         drop;
    int         lat;
    for (int i = 0; i < 40; i++) begin
      d    = 8'($urandom);
      o    = 1'($urandom);
      drop = 1'($urandom);
      do_convert(d, o, drop, lat);
      tests++;
      if (lat !== 8 || bcd !== model_bcd(d) || ovf_out !== o || sign_out !== model_sign(d)) begin
        fails++;
        $display("FAIL rand data=%02h: lat=%0d bcd=%h ovf=%b sign=%b want bcd=%h ovf=%b sign=%b",
                 d, lat, bcd, ovf_out, sign_out, model_bcd(d), o, model_sign(d));
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] held;
    int lat;
    do_convert(8'hC8, 1'b1, 1'b0, lat);
    held     = model_bcd(8'hC8);
    in_valid = 1'b1;
    in_data  = 8'h0C;
    in_ovf   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if ({state, out_valid, in_ready, bcd, ovf_out} !== {2'b10, 1'b1, 1'b0, held, 1'b1}) begin
        fails++;
        $display("FAIL bp_hold cyc=%0d: state=%b ov=%b rdy=%b bcd=%h ovf=%b", i, state, out_valid, in_ready, bcd, ovf_out);
      end
    end
    consume();
    tests++;
    if ({state, in_ready, out_valid} !== {2'b00, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL bp_release: state=%b rdy=%b ov=%b", state, in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (state !== 2'b01) begin
      fails++;
      $display("FAIL bp_accept: state=%b want 01", state);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    tests++;
    if (lat !== 8 || bcd !== 12'h012 || ovf_out !== 1'b0) begin
      fails++;
      $display("FAIL bp_next: lat=%0d bcd=%h ovf=%b want 8/012/0", lat, bcd, ovf_out);
    end
    $display("[TB] backpressure next bcd=%03h", bcd);
    consume();
  endtask

  task automatic test_rst_abort();
    int lat;
    in_valid = 1'b1;
    in_data  = 8'h99;
    in_ovf   = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    tests++;
    if (state !== 2'b01) begin
      fails++;
      $display("FAIL abort_pre: state=%b want 01", state);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({state, out_valid, bcd, ovf_out} !== {2'b00, 1'b0, 12'h000, 1'b0}) begin
      fails++;
      $display("FAIL abort_post: state=%b ov=%b bcd=%h ovf=%b", state, out_valid, bcd, ovf_out);
    end
    do_convert(8'h07, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 8 || bcd !== 12'h007) begin
      fails++;
      $display("FAIL abort_next: lat=%0d bcd=%h want 8/007", lat, bcd);
    end
    consume();
  endtask

  task automatic test_on_gate();
    logic [11:0] held;
    held      = bcd;
    on        = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({in_ready, state} !== {1'b0, 2'b00}) begin
        fails++;
        $display("FAIL on_gate cyc=%0d: rdy=%b state=%b", i, in_ready, state);
      end
    end
    in_valid  = 1'b0;
    on        = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    tests++;
    if ({state, out_valid, bcd} !== {2'b00, 1'b0, held}) begin
      fails++;
      $display("FAIL idle_out_ready: state=%b ov=%b bcd=%h want bcd=%h", state, out_valid, bcd, held);
    end
    $display("[TB] on gate state=%b", state);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_signed_cases();
    test_random();
    test_backpressure();
    test_rst_abort();
    test_on_gate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_alu_result_bcd
